palette_ram: RTL and testbench
==============================

# palette_ram

Parametrised, writable, multi-bank colour palette for the VGA sprite path. It replaces fixed per-sprite ROM palettes with one shared register-array palette holding `BANKS` palettes of `2**IDX_W` entries each. The active bank is swapped only at frame boundaries. The pixel lookup is a 2-stage registered pipeline that sits between the sprite index fetch and the VGA colour outputs.

## Interface
Parameters:
- `IDX_W`, 4: index width; each bank holds `2**IDX_W` entries.
- `CH_W`, 4: per-channel colour width; an entry is `{red, green, blue}`, `3*CH_W` bits.
- `BANKS`, 2: number of palette banks, 1..16.
- `BANK_W`, `$clog2(BANKS)` with a minimum of 1: bank select width.

Ports (name, direction, width, meaning):
- `Clk`, in, 1: pixel clock.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `pix_valid`, in, 1: `pix_index` is valid this cycle.
- `pix_index`, in, `IDX_W`: palette index to look up.
- `frame_start`, in, 1: single-cycle pulse at the start of vertical blank.
- `bank_sel`, in, `BANK_W`: requested active bank; sampled only on `frame_start`.
- `wr_en`, in, 1: palette write strobe.
- `wr_bank`, in, `BANK_W`: bank to write.
- `wr_addr`, in, `IDX_W`: entry to write.
- `wr_data`, in, `3*CH_W`: entry data, packed `{r, g, b}` with MSBs = red.
- `fade_level`, in, `CH_W`: brightness level; only used when `PALETTE_FADE_EN` is defined.
- `active_bank`, out, `BANK_W`: bank currently used for lookups.
- `out_valid`, out, 1: `red`, `green` and `blue` are valid.
- `red`, `green`, `blue`, out, `CH_W` each: colour output.

## Operation
- Storage: a register array of `BANKS * 2**IDX_W` entries, each `3*CH_W` bits. `Reset_n` low clears every entry to 0.
- Writes:
  - When `wr_en` is high, entry [`wr_bank`][`wr_addr`] takes `wr_data` on the rising edge.
  - A write with `wr_bank >= BANKS` is ignored.
  - Writes to any bank are allowed at any time, including the active bank. Tear avoidance is the caller's responsibility.
- Bank swap:
  - On a `frame_start` cycle, if `bank_sel < BANKS`, `active_bank` loads `bank_sel` at that clock edge.
  - If `bank_sel >= BANKS`, `active_bank` holds its current value.
  - `frame_start` is the only event that changes `active_bank`.
- Stage 1: registers `pix_valid` and the entry [`active_bank`][`pix_index`]. The entry is read using the `active_bank` value present in that same cycle.
- Stage 2:
  - Registers `out_valid` from stage-1 valid.
  - Registers the colour from the stage-1 entry, or its faded version when fade is compiled in.
- When stage-1 valid is 0, stage 2 still loads its colour register, but the value is don't-care. The bench must check colour only when `out_valid` is 1.
- Read/write collision: when stage 1 reads the same bank and address being written in that cycle, it captures the OLD entry (read-before-write). The new value is visible to the next lookup.
- Bank swap and lookup in the same cycle: the lookup uses the old bank. The following cycle uses the new bank. Pixels already in flight are unaffected.

## Timing
- Lookup latency is exactly 2 cycles: `pix_valid`/`pix_index` at edge N gives `out_valid`/colour at edge N+2.
- Throughput is one pixel per cycle, with no stalls and no backpressure.
- Write-to-read: a write at edge N is visible to a lookup sampled at edge N+1, with that colour appearing at output edge N+3.
- Reset values: `active_bank` = 0, `out_valid` = 0, `red`/`green`/`blue` = 0, both pipeline valid bits = 0, all palette entries = 0.
- Asserting reset mid-stream empties the pipeline immediately. The first valid output after release comes 2 cycles after the first sampled `pix_valid`.

## Configuration
- Macro: `PALETTE_FADE_EN`.
- Defined: each stage-2 channel = `(c * (fade_level + 1)) >> CH_W`, using `2*CH_W`-bit intermediate arithmetic truncated to `CH_W` bits.
  - `fade_level` = all ones gives the original colour.
  - `fade_level` = 0 gives `c >> CH_W`, which is 0 for all `c`.
  - `fade_level` is sampled in stage 2, i.e. in the cycle the product is registered.
- Not defined: stage 2 passes the colour through unchanged and `fade_level` is ignored. Latency stays 2 cycles in both builds.

## Test plan
- Reset, then lookup index 5 with `pix_valid` high: `out_valid` rises exactly 2 cycles later with colour 0,0,0.
- Write bank 0 entry 3 = 12'hCA5, then look up index 3: output `red`=C, `green`=A, `blue`=5 at N+2. Same-cycle write and lookup to entry 3 returns the previous value; the next-cycle lookup returns CA5.
- Write bank 1 entry 3 = 12'h421, set `bank_sel`=1, and stream index 3 across a `frame_start` pulse: outputs are CA5 up to and including the pulse-cycle lookup, then 421 from the next lookup. `active_bank` = 1 after the pulse. With `BANKS`=3 and `bank_sel`=3 on a pulse, `active_bank` holds.
- Toggle `pix_valid` as 1,0,1,1: `out_valid` shows the same 1,0,1,1 pattern delayed by 2 cycles.
- Assert `Reset_n` low with two pixels in flight: `out_valid` and colour go 0 asynchronously, `active_bank` = 0, and entries read back 0.
- `PALETTE_FADE_EN`, entry FFE: `fade_level`=F gives F,F,E; `fade_level`=7 gives 7,7,7; `fade_level`=0 gives 0,0,0.

Source files
------------

// File: rtl/palette_ram.sv
// palette_ram: multi-bank writable colour palette with a 2-stage registered lookup.
// Define PALETTE_FADE_EN to scale the stage-2 colour by fade_level.
module palette_ram #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CH_W   = 4,
  parameter int unsigned BANKS  = 2,
  parameter int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                pix_valid,
  input  logic [IDX_W-1:0]    pix_index,
  input  logic                frame_start,
  input  logic [BANK_W-1:0]   bank_sel,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic [CH_W-1:0]     fade_level,
  output logic [BANK_W-1:0]   active_bank,
  output logic                out_valid,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue
);

  localparam int unsigned DEPTH  = 2**IDX_W;
  localparam int unsigned ENT_W  = 3*CH_W;

  logic [ENT_W-1:0] mem [BANKS][DEPTH];
  logic             s1_valid;
  logic [ENT_W-1:0] s1_entry;
  logic [CH_W-1:0]  red_c, green_c, blue_c;

  // Palette storage; out-of-range banks are silently dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < int'(BANKS); b++) begin
        for (int a = 0; a < int'(DEPTH); a++) begin
          mem[b][a] <= '0;
        end
      end
    end else if (wr_en && (32'(wr_bank) < BANKS)) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Active bank only moves on a frame boundary with a legal request.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_bank <= '0;
    end else if (frame_start && (32'(bank_sel) < BANKS)) begin
      active_bank <= bank_sel;
    end
  end

  // Stage 1 reads with the pre-edge bank and contents (read-before-write).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_entry <= mem[active_bank][pix_index];
    end
  end

`ifdef PALETTE_FADE_EN
  localparam int unsigned PROD_W = 2*CH_W;

  function automatic logic [CH_W-1:0] fade(input logic [CH_W-1:0] c,
                                           input logic [CH_W-1:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * (PROD_W'(lvl) + PROD_W'(1));
    return CH_W'(prod >> CH_W);
  endfunction

  always_comb begin
    red_c   = fade(s1_entry[3*CH_W-1:2*CH_W], fade_level);
    green_c = fade(s1_entry[2*CH_W-1:CH_W],   fade_level);
    blue_c  = fade(s1_entry[CH_W-1:0],        fade_level);
  end
`else
  logic unused_fade;
  assign unused_fade = ^fade_level;

  always_comb begin
    red_c   = s1_entry[3*CH_W-1:2*CH_W];
    green_c = s1_entry[2*CH_W-1:CH_W];
    blue_c  = s1_entry[CH_W-1:0];
  end
`endif

  // Stage 2 output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      out_valid <= s1_valid;
      red       <= red_c;
      green     <= green_c;
      blue      <= blue_c;
    end
  end

endmodule

// File: tb/tb_palette_ram.sv
// tb_palette_ram: directed self-checking bench for palette_ram (2-bank and 3-bank instances).
module tb_palette_ram;

  logic        Clk;
  logic        Reset_n;
  logic        pix_valid, frame_start, wr_en;
  logic [3:0]  pix_index, wr_addr, fade_level;
  logic [0:0]  bank_sel, wr_bank, active_bank;
  logic [11:0] wr_data;
  logic        out_valid;
  logic [3:0]  red, green, blue;

  logic        pix_valid3, frame_start3, wr_en3, out_valid3;
  logic [3:0]  pix_index3, wr_addr3, red3, green3, blue3;
  logic [1:0]  bank_sel3, wr_bank3, active_bank3;
  logic [11:0] wr_data3;

  int checks = 0;
  int errors = 0;

  palette_ram u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .pix_index(pix_index),
    .frame_start(frame_start), .bank_sel(bank_sel), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .fade_level(fade_level),
    .active_bank(active_bank), .out_valid(out_valid), .red(red), .green(green), .blue(blue)
  );

  palette_ram #(.BANKS(3)) u_dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid3), .pix_index(pix_index3),
    .frame_start(frame_start3), .bank_sel(bank_sel3), .wr_en(wr_en3), .wr_bank(wr_bank3),
    .wr_addr(wr_addr3), .wr_data(wr_data3), .fade_level(fade_level),
    .active_bank(active_bank3), .out_valid(out_valid3), .red(red3), .green(green3), .blue(blue3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic test_reset();
    Reset_n = 1'b0;
    pix_valid = 0; pix_index = 0; frame_start = 0; bank_sel = 0;
    wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = 0; fade_level = 4'hF;
    pix_valid3 = 0; pix_index3 = 0; frame_start3 = 0; bank_sel3 = 0;
    wr_en3 = 0; wr_bank3 = 0; wr_addr3 = 0; wr_data3 = 0;
    repeat (3) @(negedge Clk);
    checks++;
    if (active_bank !== 1'b0) begin errors++; $display("FAIL reset_active_bank got %h exp 0", active_bank); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", {red, green, blue}); end
    checks++;
    if ({active_bank3, out_valid3} !== 3'b000) begin errors++; $display("FAIL reset_dut3 got %b exp 000", {active_bank3, out_valid3}); end
    Reset_n = 1'b1;
  endtask

  task automatic test_lookup_zero();
    @(negedge Clk); pix_valid = 1; pix_index = 4'd5;
    @(negedge Clk); pix_valid = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid got %b exp 0", out_valid); end
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b exp 1", out_valid); end
    checks++;
    if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL lat_rgb got %h exp 000", {red, green, blue}); end
  endtask

  task automatic test_write_read();
    @(negedge Clk);
    wr_en = 1; wr_bank = 0; wr_addr = 4'd3; wr_data = 12'hCA5;
    pix_valid = 1; pix_index = 4'd3;
    @(negedge Clk); wr_en = 0;
    @(negedge Clk); pix_valid = 0;
    checks++;
    if ({out_valid, red, green, blue} !== {1'b1, 12'h000}) begin
      errors++; $display("FAIL collision_old got %b/%h exp 1/000", out_valid, {red, green, blue});
    end
    @(negedge Clk);
    checks++;
    if ({out_valid, red, green, blue} !== {1'b1, 12'hCA5}) begin
      errors++; $display("FAIL write_then_read got %b/%h exp 1/CA5", out_valid, {red, green, blue});
    end
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL write_read_tail got %b exp 0", out_valid); end
  endtask

  task automatic test_bank_swap();
    logic [11:0] exp_rgb [4];
    exp_rgb = '{12'hCA5, 12'hCA5, 12'h421, 12'h421};
    @(negedge Clk);
    wr_en = 1; wr_bank = 1; wr_addr = 4'd3; wr_data = 12'h421; bank_sel = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      wr_en = 0;
      if (i >= 2) begin
        checks++;
        if ({out_valid, red, green, blue} !== {1'b1, exp_rgb[i-2]}) begin
          errors++; $display("FAIL swap_pixel%0d got %b/%h exp 1/%h", i-2, out_valid, {red, green, blue}, exp_rgb[i-2]);
        end
      end
      if (i == 1) begin
        checks++;
        if (active_bank !== 1'b0) begin errors++; $display("FAIL swap_before got %h exp 0", active_bank); end
      end
      if (i == 2) begin
        checks++;
        if (active_bank !== 1'b1) begin errors++; $display("FAIL swap_after got %h exp 1", active_bank); end
      end
      pix_valid = (i < 4);
      pix_index = 4'd3;
      frame_start = (i == 1);
    end
    bank_sel = 0;
    repeat (3) @(negedge Clk);
    checks++;
    if (active_bank !== 1'b1) begin errors++; $display("FAIL swap_no_pulse_hold got %h exp 1", active_bank); end
  endtask

  task automatic test_valid_pattern();
    logic pat [4];
    logic exp_v;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      exp_v = (i >= 2) ? pat[i-2] : 1'b0;
      checks++;
      if (out_valid !== exp_v) begin errors++; $display("FAIL valid_pattern%0d got %b exp %b", i, out_valid, exp_v); end
      if (exp_v) begin
        checks++;
        if ({red, green, blue} !== 12'h421) begin
          errors++; $display("FAIL valid_pattern_rgb%0d got %h exp 421", i, {red, green, blue});
        end
      end
      pix_valid = (i < 4) ? pat[i] : 1'b0;
      pix_index = 4'd3;
    end
  endtask

  task automatic test_bank_range();
    @(negedge Clk);
    wr_en3 = 1; wr_bank3 = 2; wr_addr3 = 4'd1; wr_data3 = 12'hABC;
    frame_start3 = 1; bank_sel3 = 2;
    @(negedge Clk);
    wr_en3 = 0; frame_start3 = 0;
    checks++;
    if (active_bank3 !== 2'd2) begin errors++; $display("FAIL range_sel2 got %h exp 2", active_bank3); end
    @(negedge Clk);
    frame_start3 = 1; bank_sel3 = 3; pix_valid3 = 1; pix_index3 = 4'd1;
    @(negedge Clk);
    frame_start3 = 0; pix_valid3 = 0;
    checks++;
    if (active_bank3 !== 2'd2) begin errors++; $display("FAIL range_sel3_hold got %h exp 2", active_bank3); end
    @(negedge Clk);
    checks++;
    if ({out_valid3, red3, green3, blue3} !== {1'b1, 12'hABC}) begin
      errors++; $display("FAIL range_lookup got %b/%h exp 1/ABC", out_valid3, {red3, green3, blue3});
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge Clk); pix_valid = 1; pix_index = 4'd3;
    @(negedge Clk); pix_valid = 1;
    @(negedge Clk); pix_valid = 0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre got %b exp 1", out_valid); end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, red, green, blue} !== 13'h0) begin
      errors++; $display("FAIL midreset_async got %b/%h exp 0/000", out_valid, {red, green, blue});
    end
    checks++;
    if (active_bank !== 1'b0) begin errors++; $display("FAIL midreset_bank got %h exp 0", active_bank); end
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_flushed got %b exp 0", out_valid); end
    pix_valid = 1; pix_index = 4'd3;
    @(negedge Clk); pix_valid = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_early got %b exp 0", out_valid); end
    @(negedge Clk);
    checks++;
    if ({out_valid, red, green, blue} !== {1'b1, 12'h000}) begin
      errors++; $display("FAIL midreset_cleared got %b/%h exp 1/000", out_valid, {red, green, blue});
    end
  endtask

  task automatic test_fade();
    logic [3:0]  lvls [3];
    logic [11:0] exps [3];
    lvls = '{4'hF, 4'h7, 4'h0};
`ifdef PALETTE_FADE_EN
    exps = '{12'hFFE, 12'h777, 12'h000};
`else
    exps = '{12'hFFE, 12'hFFE, 12'hFFE};
`endif
    @(negedge Clk);
    wr_en = 1; wr_bank = 0; wr_addr = 4'd7; wr_data = 12'hFFE;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      wr_en = 0; fade_level = lvls[k]; pix_valid = 1; pix_index = 4'd7;
      @(negedge Clk); pix_valid = 0;
      @(negedge Clk);
      checks++;
      if ({out_valid, red, green, blue} !== {1'b1, exps[k]}) begin
        errors++; $display("FAIL fade_lvl%h got %b/%h exp 1/%h", lvls[k], out_valid, {red, green, blue}, exps[k]);
      end
    end
    fade_level = 4'hF;
  endtask

  initial begin
    test_reset();
    test_lookup_zero();
    test_write_read();
    test_bank_swap();
    test_valid_pattern();
    test_bank_range();
    test_reset_midstream();
    test_fade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
